// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter
//   Owns the single port of the instruction memory and shares it between
//   CPU instruction fetch and a program loader. A load session stalls the
//   pipeline, waits for it to drain, optionally sweeps the memory to zero,
//   accepts program words over valid/ready, then releases the CPU.
//
//   Optional feature macro: IMEM_CLEAR_ON_LOAD_EN
//     When defined, a CLEAR state zeroes every word between DRAIN and LOAD.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   fetch_addr          byte address from the PC
//   fetch_instr/valid   instruction to the IF stage, valid only in RUN
//   cpu_stall           freezes PC and pipeline registers
//   load_req            level request for a load session
//   load_busy           high whenever the arbiter is not in RUN
//   prog_valid/ready    loader word handshake
//   prog_addr/data/last loader word byte address, data, end-of-session flag
//   prog_err            sticky flag: a bad prog_addr was rejected
//   load_count          words written in the current session (saturating)
//   mem_addr/wdata/we   instruction memory word index, write data, write enable
//   mem_rdata           instruction memory asynchronous read data
//
// state | meaning
// RUN   | CPU owns the port, zero-latency fetch
// DRAIN | pipeline stalled, waiting DRAIN_CYCLES for in-flight fetches
// CLEAR | sweep every word to zero (IMEM_CLEAR_ON_LOAD_EN only)
// LOAD  | loader owns the port, one word per beat
// DONE  | settle cycle, held until load_req is released
module imem_load_arbiter #(
  parameter  int DEPTH        = 64,
  parameter  int DRAIN_CYCLES = 4,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_instr,
  output logic          fetch_valid,
  output logic          cpu_stall,
  input  logic          load_req,
  output logic          load_busy,
  input  logic          prog_valid,
  output logic          prog_ready,
  input  logic [31:0]   prog_addr,
  input  logic [31:0]   prog_data,
  input  logic          prog_last,
  output logic          prog_err,
  output logic [AW:0]   load_count,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
);

  localparam int          DW         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [AW:0]   COUNT_MAX  = (AW + 1)'(DEPTH);
  localparam logic [31:0]   BYTE_LIMIT = 32'(4 * DEPTH);

  typedef enum logic [2:0] {RUN, DRAIN, CLEAR, LOAD, DONE} state_t;

  state_t          state;
  logic [DW-1:0]   drain_cnt;
  logic            fetch_bad;
  logic            prog_good;
  logic            beat;

`ifdef IMEM_CLEAR_ON_LOAD_EN
  localparam logic [AW-1:0] CLEAR_LAST = AW'(DEPTH - 1);
  logic [AW-1:0]   clear_cnt;
  // Remembers a load_req drop during the sweep; the sweep itself always completes.
  logic            clear_abort;
`endif

  assign fetch_bad  = (fetch_addr >= BYTE_LIMIT) || (fetch_addr[1:0] != 2'b00);
  assign prog_good  = (prog_addr < BYTE_LIMIT) && (prog_addr[1:0] == 2'b00);
  assign prog_ready = (state == LOAD);
  assign beat       = prog_valid && prog_ready;
  assign load_busy  = (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      drain_cnt  <= '0;
      load_count <= '0;
      prog_err   <= 1'b0;
`ifdef IMEM_CLEAR_ON_LOAD_EN
      clear_cnt   <= '0;
      clear_abort <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (load_req) begin
            state      <= DRAIN;
            drain_cnt  <= '0;
            prog_err   <= 1'b0;
            load_count <= '0;
          end
        end
        DRAIN: begin
          if (!load_req) begin
            state <= DONE;
          end else if (drain_cnt == DRAIN_LAST) begin
`ifdef IMEM_CLEAR_ON_LOAD_EN
            state       <= CLEAR;
            clear_cnt   <= '0;
            clear_abort <= 1'b0;
`else
            state <= LOAD;
`endif
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
`ifdef IMEM_CLEAR_ON_LOAD_EN
        CLEAR: begin
          if (!load_req) clear_abort <= 1'b1;
          if (clear_cnt == CLEAR_LAST) begin
            state <= (clear_abort || !load_req) ? DONE : LOAD;
          end else begin
            clear_cnt <= clear_cnt + 1'b1;
          end
        end
`endif
        LOAD: begin
          if (beat) begin
            if (prog_good) begin
              if (load_count != COUNT_MAX) load_count <= load_count + 1'b1;
            end else begin
              prog_err <= 1'b1;
            end
          end
          if ((beat && prog_last) || !load_req) state <= DONE;
        end
        DONE: begin
          if (!load_req) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    mem_addr    = fetch_addr[AW+1:2];
    mem_wdata   = '0;
    mem_we      = 1'b0;
    fetch_instr = '0;
    fetch_valid = 1'b0;
    cpu_stall   = 1'b1;
    case (state)
      RUN: begin
        cpu_stall   = 1'b0;
        fetch_valid = 1'b1;
        // Out-of-range or misaligned fetches return a NOP rather than aliasing.
        fetch_instr = fetch_bad ? 32'h0 : mem_rdata;
      end
      LOAD: begin
        mem_addr  = prog_addr[AW+1:2];
        mem_wdata = prog_data;
        mem_we    = beat && prog_good;
      end
`ifdef IMEM_CLEAR_ON_LOAD_EN
      CLEAR: begin
        mem_addr = clear_cnt;
        mem_we   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter with a behavioural instruction memory.
module tb_imem_load_arbiter;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk;
  logic          rst_n;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_instr;
  logic          fetch_valid;
  logic          cpu_stall;
  logic          load_req;
  logic          load_busy;
  logic          prog_valid;
  logic          prog_ready;
  logic [31:0]   prog_addr;
  logic [31:0]   prog_data;
  logic          prog_last;
  logic          prog_err;
  logic [AW:0]   load_count;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  int total = 0;
  int bad   = 0;

`ifdef IMEM_CLEAR_ON_LOAD_EN
  localparam logic [31:0] EXP_W2_AFTER_ABORT = 32'h0;
`else
  localparam logic [31:0] EXP_W2_AFTER_ABORT = 32'h3333_0000;
`endif

  imem_load_arbiter #(.DEPTH(DEPTH), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_addr(fetch_addr), .fetch_instr(fetch_instr), .fetch_valid(fetch_valid),
    .cpu_stall(cpu_stall), .load_req(load_req), .load_busy(load_busy),
    .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_last(prog_last), .prog_err(prog_err),
    .load_count(load_count), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Memory model: untouched words return a known preload pattern.
  logic [31:0]      mem [DEPTH];
  logic [DEPTH-1:0] written = '0;

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    return (a == 6'd2) ? 32'h2008_0005 : (32'hA000_0000 | 32'(a));
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
  end

  assign mem_rdata = written[mem_addr] ? mem[mem_addr] : init_word(mem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200 && !prog_ready; i++) tick();
    chk("ready_wait", 32'(prog_ready), 32'd1);
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic l);
    prog_valid = 1'b1;
    prog_addr  = a;
    prog_data  = d;
    prog_last  = l;
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    fetch_addr = 32'h8;
    load_req   = 1'b0;
    prog_valid = 1'b0;
    prog_addr  = '0;
    prog_data  = '0;
    prog_last  = 1'b0;
    #2;
    chk("rst_stall",  32'(cpu_stall),   32'd0);
    chk("rst_ready",  32'(prog_ready),  32'd0);
    chk("rst_we",     32'(mem_we),      32'd0);
    chk("rst_busy",   32'(load_busy),   32'd0);
    chk("rst_fvalid", 32'(fetch_valid), 32'd1);
    chk("rst_err",    32'(prog_err),    32'd0);
    chk("rst_count",  32'(load_count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Zero-latency fetch and NOP substitution
    chk("fetch_w2", fetch_instr, 32'h2008_0005);
    fetch_addr = 32'h6;   #1; chk("fetch_misalign", fetch_instr, 32'h0);
    chk("fetch_misalign_v", 32'(fetch_valid), 32'd1);
    fetch_addr = 32'h100; #1; chk("fetch_range", fetch_instr, 32'h0);
    fetch_addr = 32'hFC;  #1; chk("fetch_w63", fetch_instr, 32'hA000_003F);
    fetch_addr = 32'h8;

    // Session 1: three good beats
    load_req   = 1'b1;
    prog_valid = 1'b1;  // ignored until LOAD
    #1;
    chk("req_run_stall", 32'(cpu_stall), 32'd0);
    tick();
    chk("drain_stall",  32'(cpu_stall),   32'd1);
    chk("drain_fvalid", 32'(fetch_valid), 32'd0);
    chk("drain_finstr", fetch_instr,      32'h0);
    chk("drain_busy",   32'(load_busy),   32'd1);
    chk("drain_we",     32'(mem_we),      32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("drain_ready", 32'(prog_ready), 32'd0);
    end
    tick();
`ifdef IMEM_CLEAR_ON_LOAD_EN
    for (int k = 0; k < DEPTH; k++) begin
      chk("clr_we",    32'(mem_we),    32'd1);
      chk("clr_addr",  32'(mem_addr),  32'(k));
      chk("clr_wdata", mem_wdata,      32'h0);
      chk("clr_ready", 32'(prog_ready), 32'd0);
      tick();
    end
`endif
    chk("load_ready", 32'(prog_ready), 32'd1);
    beat(32'h0, 32'h1111_0000, 1'b0);
    chk("b0_we", 32'(mem_we), 32'd1);
    chk("b0_addr", 32'(mem_addr), 32'd0);
    tick();
    beat(32'h4, 32'h2222_0000, 1'b0);
    chk("b1_we", 32'(mem_we), 32'd1);
    chk("b1_addr", 32'(mem_addr), 32'd1);
    tick();
    beat(32'h8, 32'h3333_0000, 1'b1);
    chk("b2_we", 32'(mem_we), 32'd1);
    chk("b2_wdata", mem_wdata, 32'h3333_0000);
    tick();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    #1;
    chk("done_count", 32'(load_count), 32'd3);
    chk("done_ready", 32'(prog_ready), 32'd0);
    chk("done_stall", 32'(cpu_stall),  32'd1);
    chk("mem1", mem[1], 32'h2222_0000);
    tick();
    chk("done_hold", 32'(cpu_stall), 32'd1);
    load_req = 1'b0;
    tick();
    chk("run_stall", 32'(cpu_stall), 32'd0);
    chk("run_busy",  32'(load_busy), 32'd0);
    chk("run_w2",    fetch_instr,    32'h3333_0000);

    // Session 2: bad addresses
    load_req = 1'b1;
    tick();
    wait_ready();
    beat(32'h6, 32'hDEAD_0001, 1'b0);
    chk("bad6_we", 32'(mem_we), 32'd0);
    tick();
    chk("bad6_err", 32'(prog_err), 32'd1);
    beat(32'h100, 32'hDEAD_0002, 1'b0);
    chk("bad100_we", 32'(mem_we), 32'd0);
    tick();
    chk("bad_count", 32'(load_count), 32'd0);
    beat(32'h10, 32'h5555_0000, 1'b1);
    tick();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    #1;
    chk("s2_count", 32'(load_count), 32'd1);
    chk("s2_err",   32'(prog_err),   32'd1);
    load_req = 1'b0;
    tick();

    // Session 3: abort after 2 beats; prog_err clears on entry
    load_req = 1'b1;
    #1;
    chk("err_sticky", 32'(prog_err), 32'd1);
    tick();
    chk("err_clear", 32'(prog_err), 32'd0);
    chk("count_clear", 32'(load_count), 32'd0);
    wait_ready();
    beat(32'h0, 32'hAAAA_0000, 1'b0);
    tick();
    beat(32'h4, 32'hBBBB_0000, 1'b0);
    tick();
    prog_valid = 1'b0;
    load_req   = 1'b0;
    #1;
    chk("abort_ready", 32'(prog_ready), 32'd1);
    tick();
    chk("abort_done_stall", 32'(cpu_stall),  32'd1);
    chk("abort_done_ready", 32'(prog_ready), 32'd0);
    chk("abort_count",      32'(load_count), 32'd2);
    tick();
    chk("abort_run_stall", 32'(cpu_stall), 32'd0);
    chk("abort_w2", fetch_instr, EXP_W2_AFTER_ABORT);
    fetch_addr = 32'h4; #1; chk("abort_w1", fetch_instr, 32'hBBBB_0000);
    fetch_addr = 32'h0; #1; chk("abort_w0", fetch_instr, 32'hAAAA_0000);

    // load_req dropped during DRAIN
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick();
    chk("dabort_busy",  32'(load_busy),  32'd1);
    chk("dabort_ready", 32'(prog_ready), 32'd0);
    tick();
    chk("dabort_run", 32'(cpu_stall), 32'd0);

    // Reset in the middle of LOAD
    load_req = 1'b1;
    tick();
    wait_ready();
    beat(32'h6, 32'h0, 1'b0);
    tick();
    chk("pre_rst_err", 32'(prog_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_stall", 32'(cpu_stall),  32'd0);
    chk("mrst_ready", 32'(prog_ready), 32'd0);
    chk("mrst_err",   32'(prog_err),   32'd0);
    chk("mrst_count", 32'(load_count), 32'd0);
    chk("mrst_busy",  32'(load_busy),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
